msi_coherence_controller: RTL and testbench

MSI_COHERENCE_CONTROLLER -- requirements
Module: msi_coherence_controller

---
 rtl/msi_pkg.sv | 26 ++
 rtl/msi_snoop_fsm.sv | 62 ++++++
 rtl/msi_coherence_controller.sv | 83 ++++++++
 tb/tb_msi_coherence_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
// Shared encodings for the MSI coherence controller: line states and bus commands.
package msi_pkg;

   typedef enum logic [1:0] {
      ST_INVALID  = 2'b00,
      ST_MODIFIED = 2'b01,
      ST_SHARED   = 2'b10
   } msi_state_t;

   typedef enum logic [1:0] {
      BUS_INVALIDATE = 2'b00,
      BUS_WRITE_MISS = 2'b01,
      BUS_READ_MISS  = 2'b10,
      BUS_NONE       = 2'b11
   } msi_bus_t;

   // The unused code 11 reads as INVALID so a stray tag never looks owned.
   function automatic msi_state_t decode_state(input logic [1:0] raw);
      case (raw)
         2'b01:   return ST_MODIFIED;
         2'b10:   return ST_SHARED;
         default: return ST_INVALID;
      endcase
   endfunction

endpackage

// File: rtl/msi_snoop_fsm.sv
// Snoop side of the MSI controller: reacts to commands observed on the shared bus.
module msi_snoop_fsm
   import msi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] state_in,
   input  logic       read_miss,
   input  logic       write_miss,
   input  logic       invalidate,
   output logic [1:0] state_next,
   output logic       write_back_next,
   output logic       abort_next
);

   msi_state_t st;
   msi_state_t state_d;
   logic       wb_d;
   logic       abort_d;

   assign st = decode_state(state_in);

   always_comb begin
      state_d = st;
      wb_d    = 1'b0;
      abort_d = 1'b0;
      if (write_miss) begin
         state_d = ST_INVALID;
         if (st == ST_MODIFIED) begin
            wb_d    = 1'b1;
            abort_d = 1'b1;
         end
      end else if (invalidate) begin
         // Owner flushes but memory still services the invalidating requester.
         state_d = ST_INVALID;
         wb_d    = (st == ST_MODIFIED);
      end else if (read_miss) begin
         unique case (st)
            ST_MODIFIED: begin
               state_d = ST_SHARED;
               wb_d    = 1'b1;
               abort_d = 1'b1;
            end
            ST_SHARED: state_d = ST_SHARED;
            default:   state_d = ST_INVALID;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_next      <= ST_INVALID;
         write_back_next <= 1'b0;
         abort_next      <= 1'b0;
      end else begin
         state_next      <= state_d;
         write_back_next <= wb_d;
         abort_next      <= abort_d;
      end
   end

endmodule

// File: rtl/msi_coherence_controller.sv
// MSI cache coherence controller: registered CPU-side transitions plus an independent snoop path.
module msi_coherence_controller
   import msi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cpu_state_in,
   input  logic       cpu_read_hit,
   input  logic       cpu_write_hit,
   input  logic       cpu_read_miss,
   input  logic       cpu_write_miss,
   output logic [1:0] cpu_state_next,
   output logic       cpu_write_back_next,
   output logic [1:0] bus_next,
   input  logic [1:0] snoop_state_in,
   input  logic       snoop_read_miss,
   input  logic       snoop_write_miss,
   input  logic       snoop_invalidate,
   output logic [1:0] snoop_state_next,
   output logic       snoop_write_back_next,
   output logic       abort_mem_access_next
);

   msi_state_t st;
   msi_state_t state_d;
   msi_bus_t   bus_d;
   logic       wb_d;

   assign st = decode_state(cpu_state_in);

   always_comb begin
      state_d = st;
      bus_d   = BUS_NONE;
      wb_d    = 1'b0;
      if (cpu_write_miss) begin
         state_d = ST_MODIFIED;
         bus_d   = BUS_WRITE_MISS;
         wb_d    = (st == ST_MODIFIED);
      end else if (cpu_write_hit) begin
         state_d = ST_MODIFIED;
         unique case (st)
            ST_MODIFIED: bus_d = BUS_NONE;
            ST_SHARED:   bus_d = BUS_INVALIDATE;
            default:     bus_d = BUS_WRITE_MISS;
         endcase
      end else if (cpu_read_miss) begin
         state_d = ST_SHARED;
         bus_d   = BUS_READ_MISS;
         wb_d    = (st == ST_MODIFIED);
      end else if (cpu_read_hit) begin
         // A hit on an invalid line is really a miss and must fetch the block.
         if (st == ST_INVALID) begin
            state_d = ST_SHARED;
            bus_d   = BUS_READ_MISS;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_state_next      <= ST_INVALID;
         bus_next            <= BUS_NONE;
         cpu_write_back_next <= 1'b0;
      end else begin
         cpu_state_next      <= state_d;
         bus_next            <= bus_d;
         cpu_write_back_next <= wb_d;
      end
   end

   msi_snoop_fsm u_snoop (
      .clk             (clk),
      .rst             (rst),
      .state_in        (snoop_state_in),
      .read_miss       (snoop_read_miss),
      .write_miss      (snoop_write_miss),
      .invalidate      (snoop_invalidate),
      .state_next      (snoop_state_next),
      .write_back_next (snoop_write_back_next),
      .abort_next      (abort_mem_access_next)
   );

endmodule

// File: tb/tb_msi_coherence_controller.sv
// Self-checking bench for msi_coherence_controller using a table-driven reference model.
module tb_msi_coherence_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] cpu_state_in;
   logic       cpu_read_hit, cpu_write_hit, cpu_read_miss, cpu_write_miss;
   logic [1:0] cpu_state_next;
   logic       cpu_write_back_next;
   logic [1:0] bus_next;
   logic [1:0] snoop_state_in;
   logic       snoop_read_miss, snoop_write_miss, snoop_invalidate;
   logic [1:0] snoop_state_next;
   logic       snoop_write_back_next;
   logic       abort_mem_access_next;

   int compared = 0;
   int mismatched = 0;

   // Reference tables: cpu entry {state,bus,wb}; snoop entry {state,wb,abort}.
   logic [4:0] cpu_tbl [3][5];
   logic [3:0] snp_tbl [3][4];

   localparam logic [8:0] RESET_VEC = 9'b00_11_0_00_0_0;

   always #5 clk = ~clk;

   msi_coherence_controller dut (
      .clk                   (clk),
      .rst                   (rst),
      .cpu_state_in          (cpu_state_in),
      .cpu_read_hit          (cpu_read_hit),
      .cpu_write_hit         (cpu_write_hit),
      .cpu_read_miss         (cpu_read_miss),
      .cpu_write_miss        (cpu_write_miss),
      .cpu_state_next        (cpu_state_next),
      .cpu_write_back_next   (cpu_write_back_next),
      .bus_next              (bus_next),
      .snoop_state_in        (snoop_state_in),
      .snoop_read_miss       (snoop_read_miss),
      .snoop_write_miss      (snoop_write_miss),
      .snoop_invalidate      (snoop_invalidate),
      .snoop_state_next      (snoop_state_next),
      .snoop_write_back_next (snoop_write_back_next),
      .abort_mem_access_next (abort_mem_access_next)
   );

   wire [8:0] obs = {cpu_state_next, bus_next, cpu_write_back_next,
                     snoop_state_next, snoop_write_back_next, abort_mem_access_next};

   task automatic init_tables();
      // rows: 0=INVALID 1=MODIFIED 2=SHARED; cpu cols: none, rd_hit, rd_miss, wr_hit, wr_miss
      cpu_tbl[0][0] = 5'b00_11_0; cpu_tbl[0][1] = 5'b10_10_0; cpu_tbl[0][2] = 5'b10_10_0;
      cpu_tbl[0][3] = 5'b01_01_0; cpu_tbl[0][4] = 5'b01_01_0;
      cpu_tbl[1][0] = 5'b01_11_0; cpu_tbl[1][1] = 5'b01_11_0; cpu_tbl[1][2] = 5'b10_10_1;
      cpu_tbl[1][3] = 5'b01_11_0; cpu_tbl[1][4] = 5'b01_01_1;
      cpu_tbl[2][0] = 5'b10_11_0; cpu_tbl[2][1] = 5'b10_11_0; cpu_tbl[2][2] = 5'b10_10_0;
      cpu_tbl[2][3] = 5'b01_00_0; cpu_tbl[2][4] = 5'b01_01_0;
      // snoop cols: none, rd_miss, invalidate, wr_miss
      for (int c = 0; c < 4; c++) snp_tbl[0][c] = 4'b00_0_0;
      snp_tbl[1][0] = 4'b01_0_0; snp_tbl[1][1] = 4'b10_1_1;
      snp_tbl[1][2] = 4'b00_1_0; snp_tbl[1][3] = 4'b00_1_1;
      snp_tbl[2][0] = 4'b10_0_0; snp_tbl[2][1] = 4'b10_0_0;
      snp_tbl[2][2] = 4'b00_0_0; snp_tbl[2][3] = 4'b00_0_0;
   endtask

   function automatic logic [8:0] model();
      int s, r, ss, sr;
      s  = (cpu_state_in == 2'b11) ? 0 : int'(cpu_state_in);
      r  = cpu_write_miss ? 4 : cpu_write_hit ? 3 : cpu_read_miss ? 2 : cpu_read_hit ? 1 : 0;
      ss = (snoop_state_in == 2'b11) ? 0 : int'(snoop_state_in);
      sr = snoop_write_miss ? 3 : snoop_invalidate ? 2 : snoop_read_miss ? 1 : 0;
      return {cpu_tbl[s][r], snp_tbl[ss][sr]};
   endfunction

   task automatic drive(input logic [1:0] cs, input logic [3:0] creq,
                        input logic [1:0] ss, input logic [2:0] sreq);
      cpu_state_in   = cs;
      cpu_read_hit   = creq[0];
      cpu_write_hit  = creq[1];
      cpu_read_miss  = creq[2];
      cpu_write_miss = creq[3];
      snoop_state_in   = ss;
      snoop_read_miss  = sreq[0];
      snoop_invalidate = sreq[1];
      snoop_write_miss = sreq[2];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(2'b01, 4'b1111, 2'b01, 3'b111);
      step();
      compared++;
      if (obs !== RESET_VEC) begin
         mismatched++;
         $display("FAIL reset_state: got %b expected %b", obs, RESET_VEC);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [8:0] exp_v [6];
      logic [1:0] cs [6];
      logic [3:0] cr [6];
      logic [1:0] ss [6];
      logic [2:0] sr [6];
      // {cpu_state,bus,wb,snoop_state,wb,abort} derived by hand from the state rules
      cs[0] = 2'b10; cr[0] = 4'b0010; ss[0] = 2'b00; sr[0] = 3'b000; exp_v[0] = 9'b01_00_0_00_0_0;
      cs[1] = 2'b01; cr[1] = 4'b0100; ss[1] = 2'b00; sr[1] = 3'b000; exp_v[1] = 9'b10_10_1_00_0_0;
      cs[2] = 2'b00; cr[2] = 4'b0000; ss[2] = 2'b01; sr[2] = 3'b001; exp_v[2] = 9'b00_11_0_10_1_1;
      cs[3] = 2'b00; cr[3] = 4'b0000; ss[3] = 2'b10; sr[3] = 3'b110; exp_v[3] = 9'b00_11_0_00_0_0;
      cs[4] = 2'b11; cr[4] = 4'b0000; ss[4] = 2'b11; sr[4] = 3'b000; exp_v[4] = 9'b00_11_0_00_0_0;
      cs[5] = 2'b01; cr[5] = 4'b0000; ss[5] = 2'b01; sr[5] = 3'b010; exp_v[5] = 9'b01_11_0_00_1_0;
      for (int i = 0; i < 6; i++) begin
         drive(cs[i], cr[i], ss[i], sr[i]);
         step();
         compared++;
         if (obs !== exp_v[i]) begin
            mismatched++;
            $display("FAIL directed_%0d: got %b expected %b", i, obs, exp_v[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(2'b01, 4'b1000, 2'b01, 3'b001);
      rst = 1'b1;
      step();
      compared++;
      if (obs !== RESET_VEC) begin
         mismatched++;
         $display("FAIL reset_mid_hold: got %b expected %b", obs, RESET_VEC);
      end
      rst = 1'b0;
      step();
      compared++;
      if (obs !== 9'b01_01_1_10_1_1) begin
         mismatched++;
         $display("FAIL reset_mid_release: got %b expected %b", obs, 9'b01_01_1_10_1_1);
      end
   endtask

   task automatic test_random_cpu();
      logic [8:0] e;
      for (int i = 0; i < 200; i++) begin
         drive(2'($urandom_range(0, 3)), 4'($urandom), 2'b00, 3'b000);
         e = model();
         step();
         compared++;
         if (obs !== e) begin
            mismatched++;
            $display("FAIL random_cpu_%0d: in=%b got %b expected %b", i,
                     {cpu_state_in, cpu_write_miss, cpu_write_hit, cpu_read_miss, cpu_read_hit}, obs, e);
         end
      end
   endtask

   task automatic test_random_snoop();
      logic [8:0] e;
      for (int i = 0; i < 200; i++) begin
         drive(2'b00, 4'b0000, 2'($urandom_range(0, 3)), 3'($urandom));
         e = model();
         step();
         compared++;
         if (obs !== e) begin
            mismatched++;
            $display("FAIL random_snoop_%0d: in=%b got %b expected %b", i,
                     {snoop_state_in, snoop_write_miss, snoop_invalidate, snoop_read_miss}, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] e;
      for (int i = 0; i < 300; i++) begin
         drive(2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom_range(0, 3)), 3'($urandom));
         rst = ($urandom_range(0, 15) == 0);
         e = rst ? RESET_VEC : model();
         step();
         compared++;
         if (obs !== e) begin
            mismatched++;
            $display("FAIL back_to_back_%0d: rst=%b got %b expected %b", i, rst, obs, e);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      init_tables();
      rst = 1'b1;
      drive(2'b00, 4'b0000, 2'b00, 3'b000);
      test_reset();
      test_directed();
      test_reset_mid();
      test_random_cpu();
      test_random_snoop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
